// File: rtl/dff_en.sv
// -----------------------------------------------------------------------------
// dff_en
//
// Edge-triggered D flip-flop with a synchronous load enable and an
// asynchronous active-high reset. The width is set by a parameter. This is the
// basic state element for holding a value across cycles under explicit
// enable control.
//
// Parameters:
//   p_nbits        width of d and q in bits
//   p_reset_value  value forced onto q while reset is high (p_nbits wide)
//
// Ports:
//   clk    in   1        clock; state updates on the rising edge
//   reset  in   1        asynchronous, active-high reset
//   en     in   1        load enable; q takes d on a rising edge when en=1
//   d      in   p_nbits  data to be stored
//   q      out  p_nbits  registered value, driven straight from the flop
// -----------------------------------------------------------------------------
module dff_en #(
   parameter int unsigned               p_nbits       = 1,
   parameter logic [p_nbits-1:0]        p_reset_value = '0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               en,
   input  logic [p_nbits-1:0] d,
   output logic [p_nbits-1:0] q
);

   // Reset sits in the sensitivity list so q is forced as soon as reset rises,
   // and it is tested first so it wins over en on any clock edge.
   // With en=0 there is no else branch: the flop simply keeps its value, which
   // is the intended hold behaviour and not a latch (this is edge-triggered).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         // NOTE: sequential state is assigned with <= so every flop samples
         // the pre-edge values of its inputs, independent of block ordering.
         q <= p_reset_value;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: tb/tb_dff_en.sv
// -----------------------------------------------------------------------------
// tb_dff_en
//
// Self-checking bench for dff_en. Two instances share stimulus: a default
// 1-bit flop (reset value 0) and an 8-bit flop with reset value 8'hA5.
// A table of {inputs, clock action, expected q} records walks through reset,
// load, hold, reset priority and between-edge behaviour; expected values are
// queued when stimulus is driven and popped when q is sampled. A random
// load/hold phase on both instances follows, checked against a small model.
// -----------------------------------------------------------------------------
module tb_dff_en;

   typedef enum logic [1:0] {ACT_NONE, ACT_RISE, ACT_FALL} act_e;

   typedef struct {
      string      name;
      logic       rst;
      logic       en;
      logic [7:0] d;
      act_e       act;
      logic       exp1;
      logic [7:0] exp8;
   } vec_t;

   typedef struct {
      string      name;
      logic       exp1;
      logic [7:0] exp8;
   } exp_t;

   logic       clk;
   logic       reset;
   logic       en;
   logic       d1;
   logic [7:0] d8;
   logic       q1;
   logic [7:0] q8;

   int checks = 0;
   int errors = 0;

   vec_t vecs[$];
   exp_t exp_q[$];

   dff_en dut1 (
      .clk   (clk),
      .reset (reset),
      .en    (en),
      .d     (d1),
      .q     (q1)
   );

   dff_en #(
      .p_nbits       (8),
      .p_reset_value (8'hA5)
   ) dut8 (
      .clk   (clk),
      .reset (reset),
      .en    (en),
      .d     (d8),
      .q     (q8)
   );

   task automatic check(input string name, input logic [7:0] actual,
                        input logic [7:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   task automatic add(input string name, input logic rst, input logic e,
                      input logic [7:0] dv, input act_e act,
                      input logic exp1, input logic [7:0] exp8);
      vec_t v;
      v.name = name; v.rst = rst; v.en = e; v.d = dv; v.act = act;
      v.exp1 = exp1; v.exp8 = exp8;
      vecs.push_back(v);
   endtask

   // Pop the oldest expectation and compare both instances against it.
   task automatic score();
      exp_t e;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard: queue empty, got q1=%b q8=%h", q1, q8);
      end else begin
         e = exp_q.pop_front();
         check({e.name, "/q1"}, {7'b0, q1}, {7'b0, e.exp1});
         check({e.name, "/q8"}, q8, e.exp8);
      end
   endtask

   initial begin
      exp_t       e;
      logic       m1;
      logic [7:0] m8;

      clk = 1'b0; reset = 1'b0; en = 1'b0; d1 = 1'b0; d8 = 8'h00;

      //   name               rst en  d      act       q1    q8
      add("rst_async",        1, 0, 8'h00, ACT_NONE, 1'b0, 8'hA5);
      add("rst_prio_edge",    1, 1, 8'hFF, ACT_RISE, 1'b0, 8'hA5);
      add("rst_release_hi",   0, 0, 8'h00, ACT_NONE, 1'b0, 8'hA5);
      add("rst_release_fall", 0, 0, 8'h00, ACT_FALL, 1'b0, 8'hA5);
      add("load_setup",       0, 1, 8'h3D, ACT_NONE, 1'b0, 8'hA5);
      add("load_one",         0, 1, 8'h3D, ACT_RISE, 1'b1, 8'h3D);
      add("hold_high",        0, 0, 8'h00, ACT_NONE, 1'b1, 8'h3D);
      add("hold_fall",        0, 0, 8'h00, ACT_FALL, 1'b1, 8'h3D);
      add("load0_setup",      0, 1, 8'hC2, ACT_NONE, 1'b1, 8'h3D);
      add("load_zero",        0, 1, 8'hC2, ACT_RISE, 1'b0, 8'hC2);
      add("d_change_high",    0, 1, 8'hFF, ACT_NONE, 1'b0, 8'hC2);
      add("no_load_fall",     0, 1, 8'hFF, ACT_FALL, 1'b0, 8'hC2);
      add("en0_d1",           0, 0, 8'hFF, ACT_RISE, 1'b0, 8'hC2);
      add("en0_d1_fall",      0, 0, 8'hFF, ACT_FALL, 1'b0, 8'hC2);
      add("en0_d0",           0, 0, 8'h00, ACT_RISE, 1'b0, 8'hC2);
      add("en0_d0_fall",      0, 0, 8'h00, ACT_FALL, 1'b0, 8'hC2);
      add("w_load",           0, 1, 8'h3C, ACT_RISE, 1'b0, 8'h3C);
      add("w_load_fall",      0, 1, 8'h3C, ACT_FALL, 1'b0, 8'h3C);
      add("w_hold",           0, 0, 8'hFF, ACT_RISE, 1'b0, 8'h3C);
      add("w_hold_fall",      0, 0, 8'hFF, ACT_FALL, 1'b0, 8'h3C);
      add("load_01",          0, 1, 8'h01, ACT_RISE, 1'b1, 8'h01);
      add("load_01_fall",     0, 1, 8'h01, ACT_FALL, 1'b1, 8'h01);
      add("hold_one",         0, 0, 8'h00, ACT_RISE, 1'b1, 8'h01);
      add("hold_one_fall",    0, 0, 8'h00, ACT_FALL, 1'b1, 8'h01);
      add("low_change",       0, 1, 8'hFE, ACT_NONE, 1'b1, 8'h01);
      add("rst_mid",          1, 1, 8'hFF, ACT_NONE, 1'b0, 8'hA5);
      add("rst_mid_edge",     1, 1, 8'hFF, ACT_RISE, 1'b0, 8'hA5);
      add("rst_mid_fall",     1, 1, 8'hFF, ACT_FALL, 1'b0, 8'hA5);
      add("rst_off_low",      0, 1, 8'hFF, ACT_NONE, 1'b0, 8'hA5);
      add("load_after_rst",   0, 1, 8'hFF, ACT_RISE, 1'b1, 8'hFF);
      add("load_after_fall",  0, 0, 8'hFF, ACT_FALL, 1'b1, 8'hFF);
      add("hold_pre_rst",     0, 0, 8'h00, ACT_RISE, 1'b1, 8'hFF);
      add("rst_clk_high",     1, 0, 8'h00, ACT_NONE, 1'b0, 8'hA5);
      add("rst_off_fall",     0, 0, 8'h00, ACT_FALL, 1'b0, 8'hA5);
      add("rst_off_en0",      0, 0, 8'hFF, ACT_RISE, 1'b0, 8'hA5);
      add("rst_off_en0_fall", 0, 0, 8'hFF, ACT_FALL, 1'b0, 8'hA5);

      foreach (vecs[i]) begin
         reset = vecs[i].rst;
         en    = vecs[i].en;
         d8    = vecs[i].d;
         d1    = vecs[i].d[0];
         e.name = vecs[i].name; e.exp1 = vecs[i].exp1; e.exp8 = vecs[i].exp8;
         exp_q.push_back(e);
         case (vecs[i].act)
            ACT_RISE: begin #4 clk = 1'b1; #1; end
            ACT_FALL: begin #4 clk = 1'b0; #1; end
            default:  #1;
         endcase
         score();
      end

      // Random load/hold cycles; clk is low and reset is off at this point.
      m1 = 1'b0;
      m8 = 8'hA5;
      for (int i = 0; i < 40; i++) begin
         en = 1'($urandom_range(0, 1));
         d8 = 8'($urandom);
         d1 = 1'($urandom);
         if (en) begin
            m1 = d1;
            m8 = d8;
         end
         e.name = $sformatf("rand%0d", i); e.exp1 = m1; e.exp8 = m8;
         exp_q.push_back(e);
         #4 clk = 1'b1;
         #1;
         score();
         #4 clk = 1'b0;
         #1;
      end

      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0",
                  exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dff_en.md
# dff_en

Single-bit (width-parameterizable) edge-triggered D flip-flop with a synchronous load enable and an asynchronous active-high reset. It is the basic state element used wherever the datapath or control logic needs to hold a value across cycles under explicit enable control. It contains no combinational logic beyond the enable mux.

## Interface

Parameters:
- p_nbits, default 1: width of d and q in bits.
- p_reset_value, default 0: value forced onto q by reset, p_nbits wide.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  one clock; reset is asynchronous and active-high.
- en  input  1  load enable; when 1 at a rising clk edge, q takes d.
- d  input  p_nbits  data to be stored.
- q  output  p_nbits  registered value; driven directly from the storage element.

## Operation

- Reset: while reset=1, q = p_reset_value (all zeros by default) regardless of clk, en, d.
- Reset assertion takes effect immediately, without waiting for a clock edge.
- Reset has priority over en: a rising clk edge with reset=1 and en=1 still leaves q = p_reset_value.
- Load: on a rising clk edge with reset=0 and en=1, q <= d (value of d sampled at the edge).
- Hold: on a rising clk edge with reset=0 and en=0, q keeps its current value; d is ignored.
- Between rising edges (clk steady high, steady low, or falling edge), q does not change unless reset asserts.
- Changes on d or en while clk is steady never propagate to q.
- Before the first reset or load after power-up, q is undefined (X in simulation); no initial value is required.
- No other state; no combinational path from d or en to q.

## Timing

- Latency: d-to-q one rising edge when en=1.
- reset-to-q: asynchronous, combinational-delay only (zero cycles).
- Reset deassertion: q holds p_reset_value until the first rising edge with reset=0 and en=1.
- Reset deasserted in the same time step as a rising clk edge: that edge is treated as still in reset; no load occurs.
- Reset asserted mid-operation (q holding a loaded value): q returns to p_reset_value immediately and stays there until reset deasserts.
- d and en must be stable around the rising edge (standard setup/hold); only values present at the edge matter.

## Test plan

- Reset: clk=0, reset 0->1 -> q=0 immediately; then clk rises with reset=1 -> q stays 0; reset->0, clk falls -> q=0.
- Load one: after reset, clk=0, en=1, d=1 -> q stays 0; clk rises -> q=1; clk held high with en=0, d=0 -> q stays 1; clk falls -> q=1.
- Load zero: with q=1, clk=0, en=1, d=0 -> q=1; clk rises -> q=0; hold high and fall with en=0 -> q=0.
- Enable low: after reset, en=0, d=1, clk rises -> q stays 0; repeat with d=0 -> q stays 0; with q=1 loaded, en=0, d=0, rising edge -> q stays 1.
- Reset priority / mid-operation: q=1, assert reset while clk=0 with en=1, d=1 -> q=0 immediately; rising edge with reset=1 -> q=0; deassert reset, next rising edge with en=1, d=1 -> q=1.
- Width parameter: p_nbits=8, p_reset_value=8'hA5 -> reset gives q=8'hA5; en=1, d=8'h3C, rising edge -> q=8'h3C; en=0, d=8'hFF, rising edge -> q=8'h3C.
